// File: rtl/feature_buf_ctrl.sv
// Feature-map buffer controller: fills one frame of pixels from a producer,
// then serves random-access reads to a consumer until it releases the frame.
module feature_buf_ctrl #(
  parameter int DATA_WIDTH      = 16,
  parameter int POOL_ADDR_WIDTH = 10,
  parameter int NUM_PIXELS      = 784
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       layer_start,
  input  logic                       wr_req,
  input  logic [POOL_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_req,
  input  logic [POOL_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       rd_release,
  output logic                       conv_start,
  output logic                       conv_done,
  output logic [POOL_ADDR_WIDTH-1:0] address_a_t,
  output logic [DATA_WIDTH-1:0]      data_a,
  output logic                       wren_a,
  output logic                       rden_a,
  output logic                       rd_valid,
  output logic                       buf_full,
  output logic                       err
);
  // One extra counter bit so a frame of exactly 2^POOL_ADDR_WIDTH pixels fits.
  localparam int            CW   = POOL_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] NPIX = CW'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_inc;
  logic          wr_in, rd_in;
  logic          wr_acc, rd_acc, cnt_clr, done_n, err_set;
  // [1] = RAM read issued (rden_a), [2] = RAM data valid one cycle later
  logic [2:1]    vld_pipe;

  assign wr_in      = ({1'b0, wr_addr} < NPIX);
  assign rd_in      = ({1'b0, rd_addr} < NPIX);
  assign cnt_inc    = cnt + CW'(1);
  assign conv_start = (state == FILL);
  assign buf_full   = (state == READY);
  assign rden_a     = vld_pipe[1];
  assign rd_valid   = vld_pipe[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    cnt_clr = 1'b0;
    done_n  = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req || rd_req || rd_release) err_set = 1'b1;
        if (layer_start) begin
          state_n = FILL;
          cnt_clr = 1'b1;
        end
      end
      FILL: begin
        if (layer_start || rd_req || rd_release) err_set = 1'b1;
        if (wr_req) begin
          if (wr_in) begin
            wr_acc = 1'b1;
            if (cnt_inc == NPIX) begin
              state_n = READY;
              done_n  = 1'b1;
            end
          end else begin
            err_set = 1'b1;
          end
        end
      end
      READY: begin
        // layer_start here is always an error, so rd_release wins a tie.
        if (layer_start || wr_req) err_set = 1'b1;
        if (rd_req) begin
          if (rd_in) rd_acc  = 1'b1;
          else       err_set = 1'b1;
        end
        if (rd_release) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      address_a_t <= '0;
      data_a      <= '0;
      wren_a      <= 1'b0;
      vld_pipe    <= '0;
      conv_done   <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (cnt_clr)     cnt <= '0;
      else if (wr_acc) cnt <= cnt_inc;
      if (wr_acc) begin
        address_a_t <= wr_addr;
        data_a      <= wr_data;
      end else if (rd_acc) begin
        address_a_t <= rd_addr;
      end
      wren_a    <= wr_acc;
      vld_pipe  <= {vld_pipe[1], rd_acc};
      conv_done <= done_n;
      err       <= err | err_set;
    end
  end

endmodule

// File: tb/tb_feature_buf_ctrl.sv
// Self-checking bench for feature_buf_ctrl: directed scenarios plus random
// traffic compared against a frame-level behavioural model.
module tb_feature_buf_ctrl;
  localparam int DW = 16, AW = 3, NP = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          layer_start, wr_req, rd_req, rd_release;
  logic [AW-1:0] wr_addr, rd_addr, address_a_t;
  logic [DW-1:0] wr_data, data_a;
  logic          conv_start, conv_done, wren_a, rden_a, rd_valid, buf_full, err;

  // Second instance: frame size equals the full address space.
  logic       l2, w2, r2, rr2;
  logic [1:0] wa2, ra2, ad2;
  logic [7:0] wd2, da2;
  logic       cs2, cd2, we2, re2, rv2, bf2, er2;

  feature_buf_ctrl #(.DATA_WIDTH(DW), .POOL_ADDR_WIDTH(AW), .NUM_PIXELS(NP)) dut (
    .clock(clock), .reset(reset), .layer_start(layer_start), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_release(rd_release), .conv_start(conv_start), .conv_done(conv_done),
    .address_a_t(address_a_t), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
    .rd_valid(rd_valid), .buf_full(buf_full), .err(err));

  feature_buf_ctrl #(.DATA_WIDTH(8), .POOL_ADDR_WIDTH(2), .NUM_PIXELS(4)) dut2 (
    .clock(clock), .reset(reset), .layer_start(l2), .wr_req(w2),
    .wr_addr(wa2), .wr_data(wd2), .rd_req(r2), .rd_addr(ra2),
    .rd_release(rr2), .conv_start(cs2), .conv_done(cd2),
    .address_a_t(ad2), .data_a(da2), .wren_a(we2), .rden_a(re2),
    .rd_valid(rv2), .buf_full(bf2), .err(er2));

  int errors = 0, checks = 0;

  // Model: phase 0 = idle, 1 = filling, 2 = frame ready.
  int m_phase, m_cnt;
  bit m_err, m_prev_rd;
  bit e_cs, e_cd, e_we, e_re, e_rv, e_bf;
  int e_addr, e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".conv_start"}, 32'(conv_start), 32'(e_cs));
    chk({tag, ".conv_done"},  32'(conv_done),  32'(e_cd));
    chk({tag, ".wren_a"},     32'(wren_a),     32'(e_we));
    chk({tag, ".rden_a"},     32'(rden_a),     32'(e_re));
    chk({tag, ".rd_valid"},   32'(rd_valid),   32'(e_rv));
    chk({tag, ".buf_full"},   32'(buf_full),   32'(e_bf));
    chk({tag, ".err"},        32'(err),        32'(m_err));
    if (e_we || e_re) chk({tag, ".addr"}, 32'(address_a_t), 32'(e_addr));
    if (e_we)         chk({tag, ".data"}, 32'(data_a),      32'(e_data));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, ".rst_cs"},   32'(conv_start),  32'd0);
    chk({tag, ".rst_cd"},   32'(conv_done),   32'd0);
    chk({tag, ".rst_we"},   32'(wren_a),      32'd0);
    chk({tag, ".rst_re"},   32'(rden_a),      32'd0);
    chk({tag, ".rst_rv"},   32'(rd_valid),    32'd0);
    chk({tag, ".rst_bf"},   32'(buf_full),    32'd0);
    chk({tag, ".rst_err"},  32'(err),         32'd0);
    chk({tag, ".rst_addr"}, 32'(address_a_t), 32'd0);
    chk({tag, ".rst_data"}, 32'(data_a),      32'd0);
    m_phase = 0; m_cnt = 0; m_err = 1'b0; m_prev_rd = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic step(input bit ls, input bit wq, input int wa, input int wd,
                      input bit rq, input int ra, input bit rr, input string tag);
    layer_start = ls; wr_req = wq; wr_addr = AW'(wa); wr_data = DW'(wd);
    rd_req = rq; rd_addr = AW'(ra); rd_release = rr;
    e_rv = m_prev_rd; e_we = 1'b0; e_re = 1'b0; e_cd = 1'b0;
    case (m_phase)
      0: begin
        if (wq || rq || rr) m_err = 1'b1;
        if (ls) begin m_phase = 1; m_cnt = 0; end
      end
      1: begin
        if (ls || rq || rr) m_err = 1'b1;
        if (wq) begin
          if (wa < NP) begin
            e_we = 1'b1; e_addr = wa; e_data = wd; m_cnt++;
            if (m_cnt == NP) begin m_phase = 2; e_cd = 1'b1; end
          end else begin
            m_err = 1'b1;
          end
        end
      end
      default: begin
        if (ls || wq) m_err = 1'b1;
        if (rq) begin
          if (ra < NP) begin e_re = 1'b1; e_addr = ra; end
          else m_err = 1'b1;
        end
        if (rr) m_phase = 0;
      end
    endcase
    m_prev_rd = e_re;
    e_cs = (m_phase == 1);
    e_bf = (m_phase == 2);
    @(posedge clock); #1;
    layer_start = 0; wr_req = 0; rd_req = 0; rd_release = 0;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic fill_frame(input string tag);
    step(1, 0, 0, 0, 0, 0, 0, {tag, ".start"});
    for (int i = 0; i < NP; i++) step(0, 1, i, 'hA0 + i, 0, 0, 0, {tag, ".wr"});
  endtask

  initial begin
    layer_start = 0; wr_req = 0; rd_req = 0; rd_release = 0;
    wr_addr = 0; wr_data = 0; rd_addr = 0;
    l2 = 0; w2 = 0; r2 = 0; rr2 = 0; wa2 = 0; ra2 = 0; wd2 = 0;
    do_reset("init");

    // Basic fill, then back-to-back reads of 3 and 1, then release.
    fill_frame("fill");
    idle("done_clear");
    step(0, 0, 0, 0, 1, 3, 0, "rd3");
    step(0, 0, 0, 0, 1, 1, 0, "rd1");
    idle("rd_tail1");
    idle("rd_tail2");
    step(0, 0, 0, 0, 0, 0, 1, "release");

    // Protocol errors: write while idle, out-of-range read while ready.
    step(0, 1, 2, 'h55, 0, 0, 0, "wr_idle");
    fill_frame("fill2");
    step(0, 0, 0, 0, 1, 4, 0, "rd_oob");
    idle("err_sticky");

    // Read and release together: read completes after leaving READY.
    step(0, 0, 0, 0, 1, 2, 1, "rd_rel");
    idle("rd_rel_valid");

    // Reset mid-frame, then a fresh frame needs all writes again.
    do_reset("rst1");
    step(1, 0, 0, 0, 0, 0, 0, "f3.start");
    step(0, 1, 0, 'hB0, 0, 0, 0, "f3.wr0");
    step(0, 1, 1, 'hB1, 0, 0, 0, "f3.wr1");
    do_reset("rst_mid");
    fill_frame("f4");

    // Read pending when reset hits must not produce rd_valid.
    step(0, 0, 0, 0, 1, 0, 0, "rd_then_rst");
    do_reset("rst_rd");
    idle("rst_rd_tail");

    // layer_start and rd_release together in READY.
    fill_frame("f5");
    step(1, 0, 0, 0, 0, 0, 1, "ls_rel");
    idle("ls_rel_tail");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) do_reset("rnd_rst");
      step(($urandom % 6) == 0, ($urandom % 2) == 1, int'($urandom % 6),
           int'($urandom % 65536), ($urandom % 2) == 1, int'($urandom % 6),
           ($urandom % 10) == 0, "rnd");
    end

    // Frame size = full address space: ready after exactly 4 writes.
    do_reset("w2_rst");
    l2 = 1; @(posedge clock); #1; l2 = 0;
    chk("w2.conv_start", 32'(cs2), 32'd1);
    for (int k = 0; k < 4; k++) begin
      w2 = 1; wa2 = 2'(k); wd2 = 8'(8'h50 + k);
      @(posedge clock); #1; w2 = 0;
      chk("w2.wren",     32'(we2), 32'd1);
      chk("w2.addr",     32'(ad2), 32'(k));
      chk("w2.data",     32'(da2), 32'(8'h50 + k));
      chk("w2.buf_full", 32'(bf2), 32'(k == 3));
      chk("w2.conv_done", 32'(cd2), 32'(k == 3));
    end
    @(posedge clock); #1;
    chk("w2.hold_full", 32'(bf2), 32'd1);
    chk("w2.err",       32'(er2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
